// File: rtl/exc_pkg.sv
// Shared definitions for exception/ERET commit: excepttype encodings, ExcCodes,
// default exception vector and the commit FSM state encoding.
package exc_pkg;

  localparam logic [31:0] EXC_INT  = 32'h0000_0001;
  localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
  localparam logic [31:0] EXC_ADES = 32'h0000_0005;
  localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
  localparam logic [31:0] EXC_BP   = 32'h0000_0009;
  localparam logic [31:0] EXC_RI   = 32'h0000_000a;
  localparam logic [31:0] EXC_OV   = 32'h0000_000c;
  localparam logic [31:0] EXC_ERET = 32'h0000_000e;

  localparam logic [4:0] EXCCODE_INT  = 5'd0;
  localparam logic [4:0] EXCCODE_ADEL = 5'd4;
  localparam logic [4:0] EXCCODE_ADES = 5'd5;
  localparam logic [4:0] EXCCODE_SYS  = 5'd8;
  localparam logic [4:0] EXCCODE_BP   = 5'd9;
  localparam logic [4:0] EXCCODE_RI   = 5'd10;
  localparam logic [4:0] EXCCODE_OV   = 5'd12;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StCommit,
    StDrain
  } exc_state_e;

  // A delay-slot fault restarts at the branch, one word earlier.
  function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic ds);
    return ds ? (pc - 32'd4) : pc;
  endfunction

endpackage

// File: rtl/exc_commit_ctrl_if.sv
// MEM-stage exception request and the flush/CP0 update bundle of exc_commit_ctrl.
interface exc_commit_ctrl_if;

  logic        stall_i;
  logic [31:0] exc_type_i;
  logic [31:0] exc_pc_i;
  logic        exc_in_ds_i;
  logic [31:0] exc_badvaddr_i;
  logic [31:0] epc_i;

  logic        flush_o;
  logic [31:0] newpc_o;
  logic        cp0_epc_we_o;
  logic [31:0] cp0_epc_o;
  logic        cp0_cause_we_o;
  logic [4:0]  cp0_exccode_o;
  logic        cp0_bd_o;
  logic        cp0_badvaddr_we_o;
  logic [31:0] cp0_badvaddr_o;
  logic        cp0_exl_set_o;
  logic        cp0_exl_clr_o;
  logic        busy_o;

  // Pipeline/CP0 side.
  modport master (
    output stall_i, exc_type_i, exc_pc_i, exc_in_ds_i, exc_badvaddr_i, epc_i,
    input  flush_o, newpc_o, cp0_epc_we_o, cp0_epc_o, cp0_cause_we_o, cp0_exccode_o,
    input  cp0_bd_o, cp0_badvaddr_we_o, cp0_badvaddr_o, cp0_exl_set_o, cp0_exl_clr_o,
    input  busy_o
  );

  // Commit controller side.
  modport slave (
    input  stall_i, exc_type_i, exc_pc_i, exc_in_ds_i, exc_badvaddr_i, epc_i,
    output flush_o, newpc_o, cp0_epc_we_o, cp0_epc_o, cp0_cause_we_o, cp0_exccode_o,
    output cp0_bd_o, cp0_badvaddr_we_o, cp0_badvaddr_o, cp0_exl_set_o, cp0_exl_clr_o,
    output busy_o
  );

endinterface

// File: rtl/exc_type_decode.sv
// Decodes the MEM-stage excepttype into validity, ERET flag, ExcCode and
// whether BadVAddr must be written. Unknown encodings decode as "no exception".
module exc_type_decode
  import exc_pkg::*;
(
  input  logic [31:0] exc_type_i,
  output logic        valid_o,
  output logic        is_eret_o,
  output logic [4:0]  exccode_o,
  output logic        has_badvaddr_o
);

  always_comb begin
    valid_o        = 1'b0;
    is_eret_o      = 1'b0;
    exccode_o      = 5'd0;
    has_badvaddr_o = 1'b0;
    unique case (exc_type_i)
      EXC_INT: begin
        valid_o   = 1'b1;
        exccode_o = EXCCODE_INT;
      end
      EXC_ADEL: begin
        valid_o        = 1'b1;
        exccode_o      = EXCCODE_ADEL;
        has_badvaddr_o = 1'b1;
      end
      EXC_ADES: begin
        valid_o        = 1'b1;
        exccode_o      = EXCCODE_ADES;
        has_badvaddr_o = 1'b1;
      end
      EXC_SYS: begin
        valid_o   = 1'b1;
        exccode_o = EXCCODE_SYS;
      end
      EXC_BP: begin
        valid_o   = 1'b1;
        exccode_o = EXCCODE_BP;
      end
      EXC_RI: begin
        valid_o   = 1'b1;
        exccode_o = EXCCODE_RI;
      end
      EXC_OV: begin
        valid_o   = 1'b1;
        exccode_o = EXCCODE_OV;
      end
      EXC_ERET: begin
        valid_o   = 1'b1;
        is_eret_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/exc_commit_ctrl.sv
// Exception/ERET commit sequencer: captures one request, waits out stalls,
// then issues a flush with redirect pc and one-cycle CP0 update strobes.
module exc_commit_ctrl
  import exc_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEFAULT,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  exc_commit_ctrl_if.slave bus
);

  // Drain counter counts down to zero; COMMIT itself is the first flush cycle.
  localparam int unsigned DrainLoad = (FLUSH_CYCLES > 1) ? (FLUSH_CYCLES - 2) : 0;
  localparam logic [1:0]  DrainInit = DrainLoad[1:0];

  exc_state_e  state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;

  logic        dec_valid;
  logic        dec_eret;
  logic [4:0]  dec_code;
  logic        dec_bva;

  logic        eret_q;
  logic [4:0]  code_q;
  logic        bva_we_q;
  logic [31:0] pc_q;
  logic        ds_q;
  logic [31:0] bva_q;
  logic [31:0] newpc_q;
  logic [31:0] commit_pc;
  logic        capture;

  exc_type_decode u_decode (
    .exc_type_i     (bus.exc_type_i),
    .valid_o        (dec_valid),
    .is_eret_o      (dec_eret),
    .exccode_o      (dec_code),
    .has_badvaddr_o (dec_bva)
  );

  assign capture   = (state_q == StIdle) && dec_valid;
  // ERET target is taken live from CP0 in the COMMIT cycle.
  assign commit_pc = eret_q ? bus.epc_i : EXC_VECTOR;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (dec_valid) state_d = bus.stall_i ? StWait : StCommit;
      end
      StWait: begin
        if (!bus.stall_i) state_d = StCommit;
      end
      StCommit: begin
        if (FLUSH_CYCLES > 1) begin
          state_d = StDrain;
          cnt_d   = DrainInit;
        end else begin
          state_d = StIdle;
        end
      end
      StDrain: begin
        if (cnt_q == 2'd0) state_d = StIdle;
        else               cnt_d   = cnt_q - 2'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      eret_q   <= 1'b0;
      code_q   <= 5'd0;
      bva_we_q <= 1'b0;
      pc_q     <= 32'd0;
      ds_q     <= 1'b0;
      bva_q    <= 32'd0;
      newpc_q  <= 32'd0;
    end else begin
      if (capture) begin
        eret_q   <= dec_eret;
        code_q   <= dec_code;
        bva_we_q <= dec_bva;
        pc_q     <= bus.exc_pc_i;
        ds_q     <= bus.exc_in_ds_i;
        bva_q    <= bus.exc_badvaddr_i;
      end
      if (state_q == StCommit) newpc_q <= commit_pc;
    end
  end

  always_comb begin
    bus.flush_o           = 1'b0;
    bus.newpc_o           = 32'd0;
    bus.cp0_epc_we_o      = 1'b0;
    bus.cp0_epc_o         = 32'd0;
    bus.cp0_cause_we_o    = 1'b0;
    bus.cp0_exccode_o     = 5'd0;
    bus.cp0_bd_o          = 1'b0;
    bus.cp0_badvaddr_we_o = 1'b0;
    bus.cp0_badvaddr_o    = 32'd0;
    bus.cp0_exl_set_o     = 1'b0;
    bus.cp0_exl_clr_o     = 1'b0;
    bus.busy_o            = (state_q != StIdle);
    unique case (state_q)
      StCommit: begin
        bus.flush_o = 1'b1;
        bus.newpc_o = commit_pc;
        if (eret_q) begin
          bus.cp0_exl_clr_o = 1'b1;
        end else begin
          bus.cp0_epc_we_o   = 1'b1;
          bus.cp0_epc_o      = epc_of(pc_q, ds_q);
          bus.cp0_cause_we_o = 1'b1;
          bus.cp0_exccode_o  = code_q;
          bus.cp0_bd_o       = ds_q;
          bus.cp0_exl_set_o  = 1'b1;
          if (bva_we_q) begin
            bus.cp0_badvaddr_we_o = 1'b1;
            bus.cp0_badvaddr_o    = bva_q;
          end
        end
      end
      StDrain: begin
        bus.flush_o = 1'b1;
        bus.newpc_o = newpc_q;
      end
      default: ;
    endcase
  end

endmodule
